// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the SIPO receive controller.
package sipo_rx_pkg;

   localparam int SIPO_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

endpackage

// File: rtl/sipo_word_reg.sv
// Valid/ready holding register for one captured word.
// A load has priority over consumption, so a word can be replaced in the cycle it is taken.
import sipo_rx_pkg::*;

module sipo_word_reg #(
   parameter int WIDTH = SIPO_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             can_load
);

   assign can_load = !valid || ready;

   // Holding register: load new word, otherwise drop valid once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= {WIDTH{1'b0}};
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Sequencing controller for a WIDTH-bit serial-in/parallel-out shifter:
// paces serial bits, captures completed words and frames them.
import sipo_rx_pkg::*;

module sipo_rx_ctrl #(
   parameter int WIDTH = SIPO_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic [7:0]       frame_words,
   input  logic             abort,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic             shift_en,
   input  logic [WIDTH-1:0] sipo_data,
   output logic [WIDTH-1:0] word_data,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             frame_done,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       words_left;
   logic             bounded;
   logic             can_load;
   logic             load;

   assign bit_ready = (state == SHIFT);
   assign shift_en  = bit_valid && bit_ready;
   assign busy      = (state != IDLE);
   // An abort in CAPTURE discards the pending word, so it must also block the load.
   assign load      = (state == CAPTURE) && can_load && !abort;

   sipo_word_reg #(.WIDTH(WIDTH)) u_word_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (sipo_data),
      .ready     (word_ready),
      .data      (word_data),
      .valid     (word_valid),
      .can_load  (can_load)
   );

   // Frame FSM with bit and word counters; frame_done is a registered pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= {CNT_W{1'b0}};
         words_left <= 8'd0;
         bounded    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (abort) begin
            state      <= IDLE;
            bit_cnt    <= {CNT_W{1'b0}};
            words_left <= 8'd0;
            bounded    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (frame_start) begin
                     words_left <= frame_words;
                     bounded    <= (frame_words != 8'd0);
                     bit_cnt    <= {CNT_W{1'b0}};
                     state      <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (bit_valid) begin
                     if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        bit_cnt <= {CNT_W{1'b0}};
                        state   <= CAPTURE;
                     end else begin
                        bit_cnt <= bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                     end
                  end
               end
               CAPTURE: begin
                  if (can_load) begin
                     if (bounded) begin
                        words_left <= words_left - 8'd1;
                     end
                     if (bounded && (words_left == 8'd1)) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                     end else begin
                        state <= SHIFT;
                     end
                  end
               end
               default: begin
                  state   <= IDLE;
                  bit_cnt <= {CNT_W{1'b0}};
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed self-checking bench for sipo_rx_ctrl with a behavioural 4-bit SIPO
// that shifts toward bit 0, so the first bit of a word lands in bit 0.
module tb_sipo_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic [7:0] frame_words = 8'd0;
   logic       abort = 1'b0;
   logic       bit_valid = 1'b0;
   logic       serial_in = 1'b0;
   logic       bit_ready;
   logic       shift_en;
   logic [3:0] sipo_q = 4'h0;
   logic [3:0] word_data;
   logic       word_valid;
   logic       word_ready = 1'b0;
   logic       frame_done;
   logic       busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (shift_en) sipo_q <= {serial_in, sipo_q[3:1]};
   end

   sipo_rx_ctrl #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .frame_words (frame_words),
      .abort       (abort),
      .bit_valid   (bit_valid),
      .bit_ready   (bit_ready),
      .shift_en    (shift_en),
      .sipo_data   (sipo_q),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      serial_in = b;
      bit_valid = 1'b1;
      step();
      bit_valid = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w);
      for (int i = 0; i < 4; i++) send_bit(w[i]);
   endtask

   task automatic start(input logic [7:0] n);
      frame_words = n;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   initial begin
      // reset values
      step();
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_valid", {7'd0, word_valid}, 8'd0);
      check("rst_data", {4'd0, word_data}, 8'h00);
      check("rst_done", {7'd0, frame_done}, 8'd0);
      check("rst_bit_ready", {7'd0, bit_ready}, 8'd0);
      rst = 1'b0;
      step();

      // async reset mid-SHIFT after two bits
      start(8'd1);
      check("start_bit_ready", {7'd0, bit_ready}, 8'd1);
      send_bit(1'b1);
      send_bit(1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", {7'd0, busy}, 8'd0);
      check("async_rst_ready", {7'd0, bit_ready}, 8'd0);
      step();
      rst = 1'b0;
      step();
      start(8'd1);
      send_word(4'b1101);
      check("t1_capture_ready", {7'd0, bit_ready}, 8'd0);
      check("t1_capture_valid", {7'd0, word_valid}, 8'd0);
      step();
      check("t1_valid", {7'd0, word_valid}, 8'd1);
      check("t1_data", {4'd0, word_data}, 8'h0D);
      check("t1_done", {7'd0, frame_done}, 8'd1);
      check("t1_busy", {7'd0, busy}, 8'd0);
      step();
      check("t1_done_pulse", {7'd0, frame_done}, 8'd0);
      check("t1_hold_valid", {7'd0, word_valid}, 8'd1);
      check("t1_hold_data", {4'd0, word_data}, 8'h0D);
      word_ready = 1'b1;
      step();
      check("t1_consumed", {7'd0, word_valid}, 8'd0);

      // two-word frame, consumer always ready, 5 cycles per word
      start(8'd2);
      send_word(4'h1);
      check("t2_w1_capture", {7'd0, bit_ready}, 8'd0);
      step();
      check("t2_w1_valid", {7'd0, word_valid}, 8'd1);
      check("t2_w1_data", {4'd0, word_data}, 8'h01);
      check("t2_w1_shift", {7'd0, bit_ready}, 8'd1);
      check("t2_w1_nodone", {7'd0, frame_done}, 8'd0);
      send_word(4'hE);
      check("t2_w1_drained", {7'd0, word_valid}, 8'd0);
      step();
      check("t2_w2_valid", {7'd0, word_valid}, 8'd1);
      check("t2_w2_data", {4'd0, word_data}, 8'h0E);
      check("t2_done", {7'd0, frame_done}, 8'd1);
      check("t2_busy", {7'd0, busy}, 8'd0);
      step();
      check("t2_done_pulse", {7'd0, frame_done}, 8'd0);

      // unbounded frame with backpressure
      word_ready = 1'b0;
      start(8'd0);
      send_word(4'h3);
      step();
      check("t3_w1_data", {4'd0, word_data}, 8'h03);
      send_word(4'h6);
      bit_valid = 1'b1;
      step();
      check("t3_stall_ready", {7'd0, bit_ready}, 8'd0);
      check("t3_stall_shift", {7'd0, shift_en}, 8'd0);
      check("t3_stall_data", {4'd0, word_data}, 8'h03);
      check("t3_stall_busy", {7'd0, busy}, 8'd1);
      bit_valid = 1'b0;
      word_ready = 1'b1;
      #1;
      check("t3_deliver_w1", {3'd0, word_valid, word_data}, 8'h13);
      step();
      check("t3_w2_data", {3'd0, word_valid, word_data}, 8'h16);
      check("t3_resume", {7'd0, bit_ready}, 8'd1);
      word_ready = 1'b0;

      // abort after three bits with a word still valid
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t4_idle", {7'd0, busy}, 8'd0);
      check("t4_kept", {3'd0, word_valid, word_data}, 8'h16);
      check("t4_nodone", {7'd0, frame_done}, 8'd0);
      bit_valid = 1'b1;
      #1;
      check("t4_idle_noshift", {7'd0, shift_en}, 8'd0);
      bit_valid = 1'b0;
      word_ready = 1'b1;
      step();
      check("t4_drained", {7'd0, word_valid}, 8'd0);
      check("t4_still_nodone", {7'd0, frame_done}, 8'd0);
      start(8'd1);
      send_word(4'hA);
      step();
      check("t4_next_data", {4'd0, word_data}, 8'h0A);
      check("t4_next_done", {7'd0, frame_done}, 8'd1);

      // bit_valid toggling every other cycle
      start(8'd1);
      for (int i = 0; i < 4; i++) begin
         send_bit(i[0] ? 1'b0 : 1'b1);
         if (i < 3) begin
            serial_in = i[0] ? 1'b1 : 1'b0;
            step();
            check("t5_gap_ready", {7'd0, bit_ready}, 8'd1);
         end
      end
      check("t5_capture", {7'd0, bit_ready}, 8'd0);
      step();
      check("t5_data", {4'd0, word_data}, 8'h05);
      check("t5_done", {7'd0, frame_done}, 8'd1);

      // frame_start with abort, and frame_start while busy
      frame_start = 1'b1;
      abort = 1'b1;
      frame_words = 8'd1;
      step();
      frame_start = 1'b0;
      abort = 1'b0;
      check("t6_abort_wins", {7'd0, busy}, 8'd0);
      start(8'd1);
      send_bit(1'b1);
      send_bit(1'b0);
      start(8'd3);
      check("t6_busy_ignored", {7'd0, bit_ready}, 8'd1);
      send_bit(1'b0);
      send_bit(1'b1);
      check("t6_capture", {7'd0, bit_ready}, 8'd0);
      step();
      check("t6_data", {4'd0, word_data}, 8'h09);
      check("t6_done", {7'd0, frame_done}, 8'd1);
      check("t6_idle", {7'd0, busy}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
